// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- 4-requester round-robin arbiter with a registered one-hot
// grant, a binary grant index and a grant-valid flag.
//
// Optional feature: define ARB_HOLD_LIMIT_EN to cap how long one holder may
// keep the grant (HOLD_MAX consecutive cycles) while others are waiting.
// Without the macro the holder keeps the grant for as long as it requests.
//
// The winner search is split into one cell per requester (rr_arb_lane).
// Each cell decides on its own whether it is the first active request in
// rotated order from a given base index. The top level only encodes the
// one-hot result and runs the IDLE/GRANT state machine.

// One requester's slice of the rotated priority search.
module rr_arb_lane #(
  parameter int IDX = 0
) (
  input  logic [3:0] req,
  input  logic [1:0] base,
  output logic       win
);

  logic [1:0] my_dist;
  logic [1:0] dj;
  logic       blocked;

  // This lane wins when it requests and no requester sits closer to base.
  always_comb begin
    my_dist = 2'(IDX) - base;
    blocked = 1'b0;
    dj      = 2'd0;
    for (int j = 0; j < 4; j++) begin
      dj = 2'(j) - base;
      if (req[j] && (dj < my_dist)) blocked = 1'b1;
    end
    win = req[IDX] && !blocked;
  end

endmodule

module rr_arbiter4 #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam int NUM_LANES = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Catch out-of-range hold limits at elaboration rather than in silicon.
  generate
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
      $error("rr_arbiter4: HOLD_MAX must be in 2..255");
    end
  endgenerate

  state_t     state;
  logic [1:0] ptr;
`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt;
`endif

  logic [1:0]           base;
  logic [3:0]           cand;
  logic [NUM_LANES-1:0] win_oh;
  logic [1:0]           win_idx;
  logic                 any_win;
  logic                 hold_req;

  // Search base and candidate set. While granted, the search starts just
  // past the holder and the holder itself is masked out, so the same result
  // serves both a release hand-off and a forced rotation.
  always_comb begin
    if (state == GRANT) begin
      base = gnt_idx + 2'd1;
      cand = req & ~gnt;
    end else begin
      base = ptr;
      cand = req;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      rr_arb_lane #(.IDX(gi)) u_lane (
        .req  (cand),
        .base (base),
        .win  (win_oh[gi])
      );
    end
  endgenerate

  // One-hot winner to binary index.
  always_comb begin
    win_idx = 2'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (win_oh[i]) win_idx = 2'(i);
    end
    any_win = |win_oh;
  end

  assign hold_req = req[gnt_idx];

  // Arbiter state machine with registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt  <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // gnt_idx intentionally keeps the last winner while idle.
          if (any_win) begin
            gnt       <= win_oh;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            state     <= GRANT;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt  <= 8'd0;
`endif
          end
        end
        GRANT: begin
          if (!hold_req) begin
            // Holder released: priority moves past it, hand off with no bubble.
            ptr <= gnt_idx + 2'd1;
            if (any_win) begin
              gnt     <= win_oh;
              gnt_idx <= win_idx;
`ifdef ARB_HOLD_LIMIT_EN
              hold_cnt <= 8'd0;
`endif
            end else begin
              gnt       <= 4'b0000;
              gnt_valid <= 1'b0;
              state     <= IDLE;
            end
          end else begin
`ifdef ARB_HOLD_LIMIT_EN
            if (hold_cnt == 8'(HOLD_MAX - 1)) begin
              // Hold budget spent: rotate only if someone else is waiting,
              // otherwise keep the grant with the counter parked at the limit.
              if (any_win) begin
                ptr      <= gnt_idx + 2'd1;
                gnt      <= win_oh;
                gnt_idx  <= win_idx;
                hold_cnt <= 8'd0;
              end
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed scenarios with literal
// expectations plus a long randomized run, all compared every cycle against
// a behavioural owner/pointer model. Works with or without ARB_HOLD_LIMIT_EN.
module tb_rr_arbiter4;

  localparam int HOLD_MAX = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int n_assert = 0;
  int n_fail   = 0;

  rr_arbiter4 #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: who owns the resource (-1 = nobody), last winner,
  // rotation start, and how many cycles the current owner has held it.
  int m_owner = -1;
  int m_last  = 0;
  int m_ptr   = 0;
  int m_run   = 0;

  function automatic int pick(input int start, input logic [3:0] r, input int excl);
    int i;
    for (int k = 0; k < 4; k++) begin
      i = (start + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: advance on each sampled edge, clear on reset.
  always @(posedge clk or posedge rst) begin
    int w;
    if (rst) begin
      m_owner = -1;
      m_last  = 0;
      m_ptr   = 0;
      m_run   = 0;
    end else if (m_owner < 0) begin
      w = pick(m_ptr, req, -1);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_run = 1;
      end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % 4;
      w = pick(m_ptr, req, m_owner);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_run = 1;
      end else begin
        m_owner = -1;
      end
    end else begin
`ifdef ARB_HOLD_LIMIT_EN
      if (m_run >= HOLD_MAX) begin
        w = pick((m_owner + 1) % 4, req, m_owner);
        if (w >= 0) begin
          m_ptr = (m_owner + 1) % 4;
          m_owner = w; m_last = w; m_run = 1;
        end
      end else begin
        m_run++;
      end
`else
      m_run++;
`endif
    end
  end

  // Compare process: every negedge, DUT outputs against the model.
  always @(negedge clk) begin
    logic [3:0] e_gnt;
    e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    check("model_gnt",       32'(gnt),       32'(e_gnt));
    check("model_gnt_idx",   32'(gnt_idx),   32'(m_last));
    check("model_gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("onehot0_gnt",     32'($countones(gnt) <= 1), 32'd1);
  end

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [3:0] g,
                            input logic [1:0] i, input logic v);
    check({name, "_gnt"},       32'(gnt),       32'(g));
    check({name, "_gnt_idx"},   32'(gnt_idx),   32'(i));
    check({name, "_gnt_valid"}, 32'(gnt_valid), 32'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic [1:0] ei;
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset.
    repeat (5) step(4'b0000);
    expect_out("t1_idle", 4'b0000, 2'd0, 1'b0);

    // Single request, release, then requester 0 wins from ptr=3.
    do_reset();
    step(4'b0100);
    expect_out("t2_grant", 4'b0100, 2'd2, 1'b1);
    step(4'b0000);
    expect_out("t2_release", 4'b0000, 2'd2, 1'b0);
    step(4'b0001);
    expect_out("t2_next", 4'b0001, 2'd0, 1'b1);

    // All request; each holder drops after one cycle -> 0,1,2,3,0 no gap.
    do_reset();
    step(4'b1111); expect_out("t3_w0", 4'b0001, 2'd0, 1'b1);
    step(4'b1110); expect_out("t3_w1", 4'b0010, 2'd1, 1'b1);
    step(4'b1101); expect_out("t3_w2", 4'b0100, 2'd2, 1'b1);
    step(4'b1011); expect_out("t3_w3", 4'b1000, 2'd3, 1'b1);
    step(4'b0111); expect_out("t3_w0b", 4'b0001, 2'd0, 1'b1);

    // Wrap from holder 3 to requester 0 on the release edge.
    do_reset();
    step(4'b1000); expect_out("t4_h3", 4'b1000, 2'd3, 1'b1);
    step(4'b1001); expect_out("t4_keep", 4'b1000, 2'd3, 1'b1);
    step(4'b0001); expect_out("t4_wrap", 4'b0001, 2'd0, 1'b1);

    // Two constant requesters, then a lone requester.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(4'b0011);
`ifdef ARB_HOLD_LIMIT_EN
      ei = ((k / HOLD_MAX) % 2 == 0) ? 2'd0 : 2'd1;
`else
      ei = 2'd0;
`endif
      check("t5_rot_idx", 32'(gnt_idx), 32'(ei));
    end
    repeat (20) step(4'b0001);
    expect_out("t5_lone", 4'b0001, 2'd0, 1'b1);

    // Async reset mid-grant with ptr=2, then ptr must restart at 0.
    do_reset();
    step(4'b0010);
    step(4'b0000);
    step(4'b0010);
    expect_out("t6_pre", 4'b0010, 2'd1, 1'b1);
    #3 rst = 1'b1;
    #1 expect_out("t6_async", 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(4'b0110);
    expect_out("t6_ptr0", 4'b0010, 2'd1, 1'b1);

    // Randomized run with occasional mid-cycle resets.
    do_reset();
    r = 4'b0000;
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 7))
        0, 1: r = 4'($urandom_range(0, 15));
        2: if (m_owner >= 0) r[m_owner] = 1'b0;
        3: r[$urandom_range(0, 3)] ^= 1'b1;
        default: ;
      endcase
      step(r);
      if (k % 700 == 699) begin
        #3 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
